// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - data SRAM port bundle between the core pipeline and its responder
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM target: word RAM plus LED/switch/timer MMIO bank
// Optional compare timer (COUNT/COMPARE/STATUS, timer_int) enabled by `define DSRAM_TIMER_EN.
module data_sram_responder #(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
    input  logic                         clk,
    input  logic                         rst,
    data_sram_responder_if.slave         bus,
    input  logic [15:0]                  switch,
    output logic [15:0]                  led,
    output logic                         timer_int
);
    localparam logic [11:0] OFF_LED     = 12'h000;
    localparam logic [11:0] OFF_SWITCH  = 12'h004;
    localparam logic [11:0] OFF_COUNT   = 12'h008;
    localparam logic [11:0] OFF_COMPARE = 12'h00C;
    localparam logic [11:0] OFF_STATUS  = 12'h010;

    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic              is_mmio;
    logic [11:0]       offset;
    logic [RAM_AW-1:0] word_idx;
    logic [31:0]       lane_mask;
    logic              wr_req;
    logic              mmio_wr;
    logic              ram_wr;
    logic [31:0]       mmio_rdata;
    logic [31:0]       rdata_q;
    logic [15:0]       led_q;
    logic              unused_addr_bits;

    assign is_mmio  = (bus.data_sram_addr[31:16] == MMIO_HI);
    assign offset   = bus.data_sram_addr[11:0];
    assign word_idx = bus.data_sram_addr[RAM_AW+1:2];
    assign wr_req   = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
    assign mmio_wr  = wr_req && is_mmio;
    assign ram_wr   = wr_req && !is_mmio;
    // Address bits above the RAM index and the byte offset are intentionally don't-care.
    assign unused_addr_bits = ^bus.data_sram_addr;

    always_comb begin
        lane_mask = 32'h0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{bus.data_sram_wen[i]}};
        end
    end

`ifdef DSRAM_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        pending;
    logic [31:0] count_next;
    logic        timer_hit;
    logic        status_clr;

    assign timer_hit  = (count == compare) && (compare != 32'h0);
    assign status_clr = mmio_wr && (offset == OFF_STATUS) &&
                        bus.data_sram_wen[0] && bus.data_sram_wdata[0];

    // Software write wins over the increment, but only on the lanes it enables.
    always_comb begin
        count_next = count + 32'd1;
        if (mmio_wr && (offset == OFF_COUNT)) begin
            count_next = (count_next & ~lane_mask) | (bus.data_sram_wdata & lane_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 32'h0;
            compare <= 32'h0;
            pending <= 1'b0;
        end else begin
            count <= count_next;
            if (mmio_wr && (offset == OFF_COMPARE)) begin
                compare <= (compare & ~lane_mask) | (bus.data_sram_wdata & lane_mask);
            end
            pending <= timer_hit | (pending & ~status_clr);
        end
    end

    assign timer_int = pending;
`else
    assign timer_int = 1'b0;
`endif

    always_comb begin
        mmio_rdata = 32'h0;
        case (offset)
            OFF_LED:     mmio_rdata = {16'h0, led_q};
            OFF_SWITCH:  mmio_rdata = {16'h0, switch};
`ifdef DSRAM_TIMER_EN
            OFF_COUNT:   mmio_rdata = count;
            OFF_COMPARE: mmio_rdata = compare;
            OFF_STATUS:  mmio_rdata = {31'h0, pending};
`endif
            default:     mmio_rdata = 32'h0;
        endcase
    end

    // RAM array carries no reset; a reset cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && ram_wr) begin
            mem[word_idx] <= (mem[word_idx] & ~lane_mask) | (bus.data_sram_wdata & lane_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
            led_q   <= 16'h0;
        end else begin
            if (bus.data_sram_en) begin
                rdata_q <= is_mmio ? mmio_rdata : mem[word_idx];
            end
            if (mmio_wr && (offset == OFF_LED)) begin
                led_q <= (led_q & ~lane_mask[15:0]) | (bus.data_sram_wdata[15:0] & lane_mask[15:0]);
            end
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign led                 = led_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized self-checking bench for data_sram_responder
module tb_data_sram_responder;
    localparam logic [31:0] MM = 32'hBFAF_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switch;
    logic [15:0] led;
    logic        timer_int;

    data_sram_responder_if bus ();

    data_sram_responder #(.RAM_AW(12), .MMIO_HI(16'hBFAF)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .switch    (switch),
        .led       (led),
        .timer_int (timer_int)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit skip_rd = 1'b0;

    logic [31:0] m_ram [4096];
    logic [31:0] m_rdata;
    logic [15:0] m_led;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] wen);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = nw[8*i +: 8];
        end
        return res;
    endfunction

    // One clock: apply request, advance the reference model, then compare outputs.
    task automatic cycle(input logic r, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd, cnt_n, tmp;
        logic        set, clr, mmio, exp_int;
        int          idx;
        rst = r;
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        mmio = (addr[31:16] == 16'hBFAF);
        idx  = int'(addr[13:2]);
        if (r) begin
            m_rdata = 0; m_led = 0; m_count = 0; m_compare = 0; m_pending = 0;
        end else begin
            cnt_n = m_count + 1;
            set   = (m_count == m_compare) && (m_compare != 0);
            clr   = 1'b0;
            if (en) begin
                if (mmio) begin
                    case (addr[11:0])
                        12'h000: rd = {16'h0, m_led};
                        12'h004: rd = {16'h0, switch};
`ifdef DSRAM_TIMER_EN
                        12'h008: rd = m_count;
                        12'h00C: rd = m_compare;
                        12'h010: rd = {31'h0, m_pending};
`endif
                        default: rd = 0;
                    endcase
                    if (wen != 0) begin
                        case (addr[11:0])
                            12'h000: begin
                                tmp   = merge({16'h0, m_led}, wdata, wen & 4'b0011);
                                m_led = tmp[15:0];
                            end
`ifdef DSRAM_TIMER_EN
                            12'h008: cnt_n     = merge(cnt_n, wdata, wen);
                            12'h00C: m_compare = merge(m_compare, wdata, wen);
                            12'h010: clr       = wen[0] && wdata[0];
`endif
                            default: ;
                        endcase
                    end
                end else begin
                    rd = m_ram[idx];
                    if (wen != 0) m_ram[idx] = merge(m_ram[idx], wdata, wen);
                end
                m_rdata = rd;
            end
            m_count   = cnt_n;
            m_pending = set | (m_pending & ~clr);
        end
`ifdef DSRAM_TIMER_EN
        exp_int = m_pending;
`else
        exp_int = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (!skip_rd) check("rdata", bus.data_sram_rdata, m_rdata);
        check("led", {16'h0, led}, {16'h0, m_led});
        check("timer_int", {31'h0, timer_int}, {31'h0, exp_int});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        int          sel;
        switch = 16'h0;
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        check("rst_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_int", {31'h0, timer_int}, 32'h0);

        // RAM contents are unknown until written once.
        skip_rd = 1'b1;
        for (int i = 0; i < 4096; i++) cycle(1'b0, 1'b1, 4'hF, i << 2, $urandom);
        skip_rd = 1'b0;

        cycle(1'b0, 1'b1, 4'hF, 32'h10, 32'h11223344);
        cycle(1'b0, 1'b1, 4'b0100, 32'h10, 32'h00AA0000);
        cycle(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        check("byte_lane", bus.data_sram_rdata, 32'h11AA3344);

        cycle(1'b0, 1'b1, 4'hF, MM, 32'h5A5A);
        check("led_write", {16'h0, led}, 32'h5A5A);
        cycle(1'b0, 1'b1, 4'h0, MM, 32'h0);
        check("led_read", bus.data_sram_rdata, 32'h00005A5A);
        switch = 16'hBEEF;
        cycle(1'b0, 1'b1, 4'h0, MM + 4, 32'h0);
        check("switch_read", bus.data_sram_rdata, 32'h0000BEEF);

        cycle(1'b0, 1'b1, 4'hF, 32'h4000, 32'hDEADBEEF);
        cycle(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        check("alias", bus.data_sram_rdata, 32'hDEADBEEF);

        cycle(1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678);
        check("rst_wr_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_wr_led", {16'h0, led}, 32'h0);
        cycle(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
        check("rst_wr_ram", bus.data_sram_rdata, m_ram[8]);

`ifdef DSRAM_TIMER_EN
        cycle(1'b0, 1'b1, 4'hF, MM + 8, 32'h0);
        cycle(1'b0, 1'b1, 4'hF, MM + 12, 32'd5);
        repeat (4) idle();
        check("tmr_early", {31'h0, timer_int}, 32'h0);
        idle();
        check("tmr_rise", {31'h0, timer_int}, 32'h1);
        cycle(1'b0, 1'b1, 4'h1, MM + 16, 32'h1);
        check("tmr_clear", {31'h0, timer_int}, 32'h0);
        cycle(1'b0, 1'b1, 4'hF, MM + 8, 32'h20);
        cycle(1'b0, 1'b1, 4'hF, MM + 12, 32'h21);
        idle();
        check("tmr_rise2", {31'h0, timer_int}, 32'h1);
        cycle(1'b0, 1'b1, 4'hF, MM + 8, 32'h21);
        cycle(1'b0, 1'b1, 4'h1, MM + 16, 32'h1);
        check("tmr_set_wins", {31'h0, timer_int}, 32'h1);
        cycle(1'b0, 1'b1, 4'h1, MM + 16, 32'h1);
        check("tmr_clear2", {31'h0, timer_int}, 32'h0);
`else
        cycle(1'b0, 1'b1, 4'hF, MM + 8, 32'd7);
        cycle(1'b0, 1'b1, 4'h0, MM + 8, 32'h0);
        check("count_off", bus.data_sram_rdata, 32'h0);
        for (int i = 0; i < 100; i++) begin
            idle();
            check("int_off", {31'h0, timer_int}, 32'h0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 5);
            w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if (sel < 2) begin
                case ($urandom_range(0, 6))
                    0: a = MM;
                    1: a = MM + 4;
                    2: a = MM + 8;
                    3: a = MM + 12;
                    4: a = MM + 16;
                    5: a = MM + 20;
                    default: a = MM + 32'hFFC;
                endcase
                if (a[11:0] == 12'h008 && $urandom_range(0, 3) != 0) w = 4'h0;
            end else begin
                a = $urandom;
                if (a[31:16] == 16'hBFAF) a[31:16] = 16'h0000;
            end
            switch = 16'($urandom);
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), w, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
